// File: rtl/day1_pkg.sv
// Shared types and ASCII constants for the day1 stream sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
package day1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DIR,
        ST_NUM,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/day1_sequencer.sv
// Parses an ASCII rotation stream, feeds day1_puzzle one command at a time, latches the final password.
// Latency: byte accepted at edge N -> valid from cycle N+1; result DRAIN_CYCLES ready cycles after the last transfer.
// Backpressure: in_ready drops while a command waits on ready; valid/rotation/rotate_amount held until ready.
module day1_sequencer
    import day1_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int START_POS    = 50,
    parameter int MAX_NUMBER   = 99,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             init,
    output logic             valid,
    output logic             rotation,
    output logic [WIDTH-1:0] rotate_amount,
    output logic [WIDTH-1:0] max_number,
    input  logic             ready,
    input  logic [WIDTH-1:0] password,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic [WIDTH-1:0] cmd_count,
    output logic             error
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic             last_q, last_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [DW-1:0]    drain_q, drain_d;

    // acc*10 + digit in four extra bits; any carry into them means overflow
    logic [WIDTH+3:0] acc_ext;
    logic [WIDTH+3:0] acc_mul;
    logic             acc_sat;
    assign acc_ext = {4'b0000, acc_q};
    assign acc_mul = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, in_data[3:0]};
    assign acc_sat = |acc_mul[WIDTH+3:WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            last_q   <= 1'b0;
            error_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            last_q   <= last_d;
            error_q  <= error_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            drain_q  <= drain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        last_d   = last_q;
        error_d  = error_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        drain_d  = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_INIT;
                    cnt_d    = '0;
                    error_d  = 1'b0;
                    result_d = '0;
                end
            end
            ST_INIT: begin
                state_d = ST_DIR;
                last_d  = 1'b0;
            end
            ST_DIR: begin
                if (in_valid) begin
                    if (in_data == CH_L || in_data == CH_R) begin
                        dir_d   = (in_data == CH_R);
                        acc_d   = '0;
                        state_d = ST_NUM;
                    end else if (in_data != CH_LF && in_data != CH_CR) begin
                        error_d = 1'b1;
                    end
                    if (in_last) state_d = ST_DRAIN;
                end
            end
            ST_NUM: begin
                if (in_valid) begin
                    if (is_digit(in_data)) begin
                        acc_d = acc_sat ? '1 : acc_mul[WIDTH-1:0];
                        if (acc_sat) error_d = 1'b1;
                        if (in_last) begin
                            state_d = ST_ISSUE;
                            last_d  = 1'b1;
                        end
                    end else if (in_data == CH_LF) begin
                        state_d = ST_ISSUE;
                        last_d  = in_last;
                    end else if (in_data == CH_CR) begin
                        if (in_last) begin
                            state_d = ST_ISSUE;
                            last_d  = 1'b1;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = in_last ? ST_DRAIN : ST_DIR;
                    end
                end
            end
            ST_ISSUE: begin
                if (ready) begin
                    cnt_d   = cnt_q + WIDTH'(1);
                    state_d = last_q ? ST_DRAIN : ST_DIR;
                end
            end
            ST_DRAIN: begin
                if (ready) begin
                    if (drain_q == DRAIN_LAST) begin
                        result_d = password;
                        state_d  = ST_DONE;
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = 1'b0;
        init          = 1'b0;
        valid         = 1'b0;
        rotation      = 1'b0;
        rotate_amount = '0;
        done          = 1'b0;
        max_number    = (state_q != ST_IDLE) ? WIDTH'(MAX_NUMBER) : '0;
        case (state_q)
            ST_INIT: begin
                init          = 1'b1;
                rotate_amount = WIDTH'(START_POS);
            end
            ST_DIR, ST_NUM: in_ready = 1'b1;
            ST_ISSUE: begin
                valid         = 1'b1;
                rotation      = dir_q;
                rotate_amount = acc_q;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign result    = result_q;
    assign cmd_count = cnt_q;
    assign error     = error_q;

endmodule

// File: tb/tb_day1_sequencer.sv
// Bench for day1_sequencer: plays the puzzle side itself and checks streams against table and random commands.
// Latency: n/a. Backpressure: ready is randomised, stalled for 5 cycles per command, or held low.
module tb_day1_sequencer;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset, start, in_valid, in_last, ready;
    logic [7:0]   in_data;
    logic [W-1:0] password;
    logic         in_ready, init, valid, rotation, done, error;
    logic [W-1:0] rotate_amount, max_number, result, cmd_count;

    day1_sequencer #(.WIDTH(W), .START_POS(50), .MAX_NUMBER(99), .DRAIN_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .init(init), .valid(valid), .rotation(rotation), .rotate_amount(rotate_amount),
        .max_number(max_number), .ready(ready), .password(password),
        .result(result), .done(done), .cmd_count(cmd_count), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct { bit r; int amt; } cmd_t;
    typedef struct { string s; int pm; int rm; int cnt; int res; bit err; } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   mode, rmode;
    cmd_t got[$];
    cmd_t exp_q[$];

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected password from the dial rules, closed form per command.
    function automatic int answer(int pm);
        int p = 50;
        int n = 0;
        foreach (exp_q[k]) begin
            int a = exp_q[k].amt;
            if (pm == 1) begin
                p = exp_q[k].r ? (p + a) % 100 : (p + 100 - a % 100) % 100;
                if (p == 0) n++;
            end else if (exp_q[k].r) begin
                n += (p + a) / 100;
                p = (p + a) % 100;
            end else begin
                if (p == 0) n += a / 100;
                else if (a >= p) n += 1 + (a - p) / 100;
                p = ((p - a) % 100 + 100) % 100;
            end
        end
        return n;
    endfunction

    // Puzzle stand-in: walks the dial click by click and exposes the live password.
    initial begin : puzzle
        int  pos, pw, vcnt;
        bit  prev_stall, prev_rot;
        int  prev_amt;
        ready = 1'b0; password = '0;
        pos = 0; pw = 0; vcnt = 0; prev_stall = 0; prev_rot = 0; prev_amt = 0;
        forever begin
            @(negedge clock);
            if (init) begin
                check("init_not_valid", valid, 0);
                check("init_amount", rotate_amount, 50);
                check("init_max", max_number, 99);
                pos = rotate_amount; pw = 0; password = '0;
            end
            if (valid) vcnt++; else vcnt = 0;
            if (valid && prev_stall) begin
                check("hold_rotation", rotation, prev_rot);
                check("hold_amount", rotate_amount, prev_amt);
            end
            case (rmode)
                0:       ready = ($urandom_range(0, 2) != 0);
                1:       ready = !valid || (vcnt > 5);
                default: ready = !valid;
            endcase
            if (valid && ready) begin
                if (rmode == 1) check("stall_cycles", vcnt, 6);
                got.push_back('{r: rotation, amt: int'(rotate_amount)});
                for (int k = 0; k < int'(rotate_amount); k++) begin
                    pos = rotation ? (pos + 1) % 100 : (pos + 99) % 100;
                    if (mode == 2 && pos == 0) pw++;
                end
                if (mode == 1 && pos == 0) pw++;
                password = pw[W-1:0];
            end
            prev_stall = valid && !ready;
            prev_rot   = rotation;
            prev_amt   = int'(rotate_amount);
        end
    end

    task automatic send_byte(byte c, bit last, bit rnd, output bit ok);
        int gaps;
        bit acc;
        gaps = rnd ? $urandom_range(0, 2) : 0;
        start = 1'b0;
        repeat (gaps) begin
            in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
            @(posedge clock); #1;
        end
        in_valid = 1'b1; in_data = c; in_last = last;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (rnd) start = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            acc = in_ready;
            @(posedge clock); #1;
            if (acc) begin ok = 1; break; end
        end
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        if (!ok) check("byte_accept_timeout", 0, 1);
    endtask

    task automatic do_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        check("start_init_n1", init, 1);
        check("start_in_ready_n1", in_ready, 0);
        @(negedge clock);
        check("start_in_ready_n2", in_ready, 1);
        check("start_cleared_count", cmd_count, 0);
        check("start_cleared_done", done, 0);
        @(posedge clock); #1;
    endtask

    task automatic send_str(string s, bit use_last, bit rnd, output bit ok);
        ok = 1;
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], use_last && (i == s.len() - 1), rnd, ok);
            if (!ok) break;
        end
    endtask

    task automatic run_stream(string s, int pm, int rm, bit rnd);
        bit ok;
        bit seen;
        mode = pm; rmode = rm; got.delete();
        do_start();
        send_str(s, 1, rnd, ok);
        seen = 0;
        for (int i = 0; i < 5000 && ok; i++) begin
            @(negedge clock);
            if (done) begin seen = 1; break; end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    localparam string EX = "L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\n";

    initial begin : main
        vec_t  vt[5];
        bit    ok;
        string s;
        int    n, pm;
        logic [W-1:0] r0;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        mode = 1; rmode = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_init", init, 0);
        check("rst_valid", valid, 0);
        check("rst_rotation", rotation, 0);
        check("rst_amount", rotate_amount, 0);
        check("rst_max", max_number, 0);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_count", cmd_count, 0);
        check("rst_error", error, 0);
        reset = 1'b0;

        vt[0] = '{s: EX, pm: 1, rm: 0, cnt: 10, res: 3, err: 0};
        vt[1] = '{s: EX, pm: 2, rm: 0, cnt: 10, res: 6, err: 0};
        vt[2] = '{s: "\r\nL12\r\n\r\n\nR7", pm: 1, rm: 0, cnt: 2, res: 0, err: 0};
        vt[3] = '{s: "L70000\nX5\n", pm: 2, rm: 0, cnt: 1, res: 655, err: 1};
        vt[4] = '{s: "R10\nL3\nR290\n", pm: 2, rm: 1, cnt: 3, res: 3, err: 0};

        for (int i = 0; i < 5; i++) begin
            run_stream(vt[i].s, vt[i].pm, vt[i].rm, 0);
            check($sformatf("vec%0d_count", i), cmd_count, vt[i].cnt);
            check($sformatf("vec%0d_result", i), result, vt[i].res);
            check($sformatf("vec%0d_error", i), error, vt[i].err);
            check($sformatf("vec%0d_transfers", i), got.size(), vt[i].cnt);
            if (i == 2 && got.size() == 2) begin
                check("crlf_last_rot", got[1].r, 1);
                check("crlf_last_amt", got[1].amt, 7);
            end
            if (i == 3 && got.size() == 1) check("sat_amount", got[0].amt, 65535);
            r0 = result;
            in_valid = 1'b1; in_data = "L";
            repeat (3) @(negedge clock);
            in_valid = 1'b0;
            check($sformatf("vec%0d_done_held", i), done, 1);
            check($sformatf("vec%0d_done_in_ready", i), in_ready, 0);
            check($sformatf("vec%0d_result_held", i), result, r0);
        end

        // Abort a run while a command is stuck waiting on ready.
        mode = 1; rmode = 2; got.delete();
        do_start();
        send_str("R10\n", 0, 0, ok);
        @(negedge clock);
        check("abort_pre_valid", valid, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_valid", valid, 0);
        check("abort_done", done, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_init", init, 0);
        check("abort_max", max_number, 0);
        check("abort_no_transfer", got.size(), 0);
        run_stream(EX, 1, 0, 0);
        check("rerun_count", cmd_count, 10);
        check("rerun_result", result, 3);

        for (int t = 0; t < 6; t++) begin
            exp_q.delete();
            s = "";
            n = $urandom_range(3, 8);
            for (int k = 0; k < n; k++) begin
                cmd_t c;
                c.r = 1'($urandom);
                c.amt = $urandom_range(0, 999);
                exp_q.push_back(c);
                if ($urandom_range(0, 3) == 0) s = {s, ($urandom_range(0, 1) != 0) ? "\r\n" : "\n"};
                s = {s, c.r ? "R" : "L", $sformatf("%0d", c.amt)};
                if (k != n - 1 || $urandom_range(0, 1) != 0)
                    s = {s, ($urandom_range(0, 1) != 0) ? "\r\n" : "\n"};
            end
            pm = $urandom_range(1, 2);
            run_stream(s, pm, 0, 1);
            check($sformatf("rnd%0d_count", t), cmd_count, n);
            check($sformatf("rnd%0d_result", t), result, answer(pm));
            check($sformatf("rnd%0d_error", t), error, 0);
            check($sformatf("rnd%0d_transfers", t), got.size(), n);
            for (int k = 0; k < n && k < got.size(); k++) begin
                check($sformatf("rnd%0d_cmd%0d_rot", t, k), got[k].r, exp_q[k].r);
                check($sformatf("rnd%0d_cmd%0d_amt", t, k), got[k].amt, exp_q[k].amt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
